// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the writeback path: writeback source selects
// and load funct3 codes.
package rv32i_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Combinational load lane select and sign/zero extension from an aligned word.
// Misaligned or unknown load widths raise fault and return zero data.
module load_extract
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data  = 32'h0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        if (off[0]) fault = 1'b1;
        else        data  = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off[0]) fault = 1'b1;
        else        data  = {16'h0, half_sel};
      end
      F3_LW: begin
        if (off != 2'b00) fault = 1'b1;
        else              data  = rdata;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback value, gates RegWrite on
// faults and x0, and registers everything so outputs come straight from flops.
module mem_wb_stage
  import rv32i_pkg::*;
#(
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_RegWrite,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] pc_plus4,
  output logic [4:0]  rd,
  output logic        RegWrite,
  output logic [31:0] C,
  output logic        wb_valid,
  output logic        load_fault
);

  logic [31:0] ld_data;
  logic        ld_fault_raw;
  logic        nxt_fault;
  logic        nxt_regwrite;
  logic [31:0] nxt_c;

  load_extract u_load_extract (
    .funct3 (mem_funct3),
    .off    (alu_result[1:0]),
    .rdata  (mem_rdata),
    .data   (ld_data),
    .fault  (ld_fault_raw)
  );

  // Fault is only meaningful for an actual load; other sources ignore funct3/offset.
  assign nxt_fault = (mem_wb_sel == WB_SEL_LOAD) && ld_fault_raw;

  always_comb begin
    nxt_c = 32'h0;
    case (mem_wb_sel)
      WB_SEL_ALU:  nxt_c = alu_result;
      WB_SEL_LOAD: nxt_c = ld_data;
      WB_SEL_PC4:  nxt_c = pc_plus4;
      default:     nxt_c = 32'h0;
    endcase
  end

  always_comb begin
    nxt_regwrite = mem_RegWrite;
    if (mem_wb_sel == 2'b11)                    nxt_regwrite = 1'b0;
    if (nxt_fault)                              nxt_regwrite = 1'b0;
    if (ZERO_RD_SUPPRESS && (mem_rd == 5'd0))   nxt_regwrite = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd         <= 5'd0;
      RegWrite   <= 1'b0;
      C          <= 32'h0;
      wb_valid   <= 1'b0;
      load_fault <= 1'b0;
    end else if (flush || (!stall && !mem_valid)) begin
      rd         <= 5'd0;
      RegWrite   <= 1'b0;
      C          <= 32'h0;
      wb_valid   <= 1'b0;
      load_fault <= 1'b0;
    end else if (!stall) begin
      rd         <= mem_rd;
      RegWrite   <= nxt_regwrite;
      C          <= nxt_c;
      wb_valid   <= 1'b1;
      load_fault <= nxt_fault;
    end
  end

endmodule
